ring_monitor: RTL and testbench

Downstream checker and decoder for the 8-bit circular one-hot shift register. Samples the rotating ring pattern every clock, converts the active bit to a binary position, counts completed revolutions, and latches a sticky fault when the pattern stops being a legal one-hot rotate-right sequence. Its outputs drive status display and self-test logic; it never drives the ring.

---
 rtl/ring_monitor.sv | 103 ++++++++++
 tb/tb_ring_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ring_monitor.sv
// ring_monitor: checks, decodes and counts revolutions of a rotate-right one-hot ring
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   ring               : sampled ring pattern
//   clear              : clears fault/fault_code and revolutions
//   position           : set-bit index of the last accepted pattern
//   position_valid     : high while tracking a legal sequence
//   revolutions        : completed wraps, saturating
//   fault, fault_code  : sticky fault; 1 = not one-hot, 2 = illegal step, 3 = stuck
module ring_monitor #(
    parameter int WIDTH       = 8,
    parameter int REV_WIDTH   = 16,
    parameter int STALL_LIMIT = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] position,
    output logic                     position_valid,
    output logic [REV_WIDTH-1:0]     revolutions,
    output logic                     fault,
    output logic [1:0]               fault_code
);
    localparam int PW = $clog2(WIDTH);
    localparam int SW = $clog2(STALL_LIMIT + 2);
    typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;
    state_t               state, state_n;
    logic [WIDTH-1:0]     prev, prev_n;
    logic [SW-1:0]        stall_cnt, stall_n, stall_inc;
    logic [PW-1:0]        position_n, idx;
    logic [REV_WIDTH-1:0] rev_n;
    logic [1:0]           code_n;
    logic                 onehot, stuck;
    assign onehot    = (ring != '0) && ((ring & (ring - 1'b1)) == '0);
    assign stall_inc = (stall_cnt > SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
    assign stuck     = stall_inc > SW'(STALL_LIMIT);
    assign position_valid = state == TRACK;
    assign fault          = state == FAULT;
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (ring[i]) idx = PW'(i);
    end
    always_comb begin
        state_n    = state;
        prev_n     = prev;
        stall_n    = stall_cnt;
        position_n = position;
        rev_n      = clear ? '0 : revolutions;
        code_n     = fault_code;
        case (state)
            ACQUIRE: if (onehot) begin
                prev_n     = ring;
                position_n = idx;
                stall_n    = '0;
                state_n    = TRACK;
            end
            TRACK: begin
                if (!onehot) begin
                    state_n = FAULT;
                    code_n  = 2'd1;
                end else if (ring == prev) begin
                    stall_n = stall_inc;
                    if (stuck) begin
                        state_n = FAULT;
                        code_n  = 2'd3;
                    end
                end else if (ring == {prev[0], prev[WIDTH-1:1]}) begin
                    // prev[0] set means this legal step is the wrap back to the MSB
                    if (prev[0] && !clear && revolutions != '1) rev_n = revolutions + 1'b1;
                    prev_n     = ring;
                    position_n = idx;
                    stall_n    = '0;
                end else begin
                    state_n = FAULT;
                    code_n  = 2'd2;
                end
            end
            FAULT: if (clear) begin
                state_n = ACQUIRE;
                code_n  = 2'd0;
            end
            default: state_n = ACQUIRE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ACQUIRE;
            prev        <= '0;
            stall_cnt   <= '0;
            position    <= '0;
            revolutions <= '0;
            fault_code  <= '0;
        end else begin
            state       <= state_n;
            prev        <= prev_n;
            stall_cnt   <= stall_n;
            position    <= position_n;
            revolutions <= rev_n;
            fault_code  <= code_n;
        end
    end
endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: directed scoreboard bench for ring_monitor (plus a REV_WIDTH=2 instance)
module tb_ring_monitor;
    logic        clock = 0, reset = 1, clear = 0;
    logic [7:0]  ring = 0;
    logic [2:0]  position, position_s;
    logic        position_valid, position_valid_s, fault, fault_s;
    logic [15:0] revolutions;
    logic [1:0]  revolutions_s, fault_code, fault_code_s;
    ring_monitor u_dut (
        .clock(clock), .reset(reset), .ring(ring), .clear(clear),
        .position(position), .position_valid(position_valid),
        .revolutions(revolutions), .fault(fault), .fault_code(fault_code)
    );
    ring_monitor #(.REV_WIDTH(2)) u_sat (
        .clock(clock), .reset(reset), .ring(ring), .clear(clear),
        .position(position_s), .position_valid(position_valid_s),
        .revolutions(revolutions_s), .fault(fault_s), .fault_code(fault_code_s)
    );
    always #5 clock = ~clock;
    typedef struct {
        int pos; int pv; int rev; int rev2; int flt; int code;
    } exp_t;
    exp_t sb[$];
    int total = 0, passed = 0, fails = 0;
    int m_st, m_pos, m_rev, m_rev2, m_stall, m_code;
    logic [7:0] m_prev;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model(logic rst, logic [7:0] r, logic c);
        int idx = 0;
        for (int i = 0; i < 8; i++) if (r[i]) idx = i;
        if (rst) begin
            m_st = 0; m_prev = 0; m_pos = 0; m_rev = 0; m_rev2 = 0; m_stall = 0; m_code = 0;
        end else begin
            if (c) begin m_rev = 0; m_rev2 = 0; end
            if (m_st == 0) begin
                if ($countones(r) == 1) begin
                    m_prev = r; m_pos = idx; m_stall = 0; m_st = 1;
                end
            end else if (m_st == 1) begin
                if ($countones(r) != 1) begin
                    m_st = 2; m_code = 1;
                end else if (r == m_prev) begin
                    m_stall++;
                    if (m_stall > 15) begin m_st = 2; m_code = 3; end
                end else if (r == {m_prev[0], m_prev[7:1]}) begin
                    if (m_prev == 8'h01 && !c) begin
                        if (m_rev < 65535) m_rev++;
                        if (m_rev2 < 3) m_rev2++;
                    end
                    m_prev = r; m_pos = idx; m_stall = 0;
                end else begin
                    m_st = 2; m_code = 2;
                end
            end else if (c) begin
                m_st = 0; m_code = 0;
            end
        end
        sb.push_back('{m_pos, int'(m_st == 1), m_rev, m_rev2, int'(m_st == 2), m_code});
    endtask
    task automatic step(string tag, logic rst, logic [7:0] r, logic c);
        exp_t e;
        reset = rst; ring = r; clear = c;
        model(rst, r, c);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pos"},   position,       e.pos);
            chk({tag, "_pv"},    position_valid, e.pv);
            chk({tag, "_rev"},   revolutions,    e.rev);
            chk({tag, "_rev2"},  revolutions_s,  e.rev2);
            chk({tag, "_fault"}, fault,          e.flt);
            chk({tag, "_code"},  fault_code,     e.code);
        end
    endtask
    task automatic run(string tag, logic [7:0] start, int n);
        logic [7:0] r = start;
        repeat (n) begin
            step(tag, 0, r, 0);
            r = {r[0], r[7:1]};
        end
    endtask
    task automatic chk_reset(string tag);
        chk({tag, "_pos0"},   position,       0);
        chk({tag, "_pv0"},    position_valid, 0);
        chk({tag, "_rev0"},   revolutions,    0);
        chk({tag, "_fault0"}, fault,          0);
        chk({tag, "_code0"},  fault_code,     0);
    endtask
    initial begin
        step("reset", 1, 8'h00, 0);
        step("reset", 1, 8'h00, 0);
        chk_reset("reset");
        run("rev1", 8'h80, 9);
        chk("rev1_count", revolutions, 1);
        chk("rev1_pos", position, 7);
        run("walk", 8'h40, 2);
        repeat (15) step("hold15", 0, 8'h20, 0);
        run("after_hold", 8'h10, 7);
        chk("hold15_nofault", fault, 0);
        step("to20", 0, 8'h20, 0);
        repeat (16) step("hold16", 0, 8'h20, 0);
        chk("stuck_fault", fault, 1);
        chk("stuck_code", fault_code, 3);
        chk("stuck_pos", position, 5);
        step("ignore", 0, 8'hFF, 0);
        step("ignore", 0, 8'h01, 0);
        step("clr1", 0, 8'h00, 1);
        step("acq10", 0, 8'h10, 0);
        step("multi", 0, 8'h18, 0);
        chk("multi_code", fault_code, 1);
        step("clr2", 0, 8'h04, 1);
        step("acq04", 0, 8'h04, 0);
        chk("reacq_pos", position, 2);
        chk("reacq_pv", position_valid, 1);
        run("pre", 8'h02, 4);
        step("jump80", 0, 8'h80, 0);
        chk("jump_code", fault_code, 2);
        step("clr3", 0, 8'h40, 1);
        step("acq40", 0, 8'h40, 0);
        step("skip", 0, 8'h10, 0);
        chk("skip_code", fault_code, 2);
        step("clr4", 0, 8'h00, 1);
        step("acq80", 0, 8'h80, 0);
        run("revs3", 8'h40, 24);
        chk("revs3_count", revolutions, 3);
        run("revs3", 8'h40, 7);
        step("wrap_clr", 0, 8'h80, 1);
        chk("wrap_clr_rev", revolutions, 0);
        chk("wrap_clr_pos", position, 7);
        run("sat", 8'h40, 40);
        chk("sat_rev", revolutions, 5);
        chk("sat_rev2", revolutions_s, 3);
        step("clr_fault", 0, 8'h20, 1);
        chk("clr_fault_code", fault_code, 2);
        step("rst_fault", 1, 8'h80, 0);
        chk_reset("rst_fault");
        step("acq_zero", 0, 8'h00, 0);
        step("acq_ff", 0, 8'hFF, 0);
        chk("acq_ff_pv", position_valid, 0);
        step("acq08", 0, 8'h08, 0);
        step("trk04", 0, 8'h04, 0);
        step("rst_clr", 1, 8'h02, 1);
        chk_reset("rst_clr");
        step("acq_zero2", 0, 8'h00, 0);
        step("acq_ff2", 0, 8'hFF, 0);
        chk("acq_ff2_fault", fault, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
